// File: rtl/lev_cmd_pkg.sv
// Shared constants, state encoding and configuration record for the levitation command path.
// Latency: none (declarations and a pure combinational helper only).
// Backpressure: none; the helper has no flow control.
package lev_cmd_pkg;

  // Frame delimiters and host response bytes
  localparam logic [7:0] SOF = 8'hFF;
  localparam logic [7:0] EOF = 8'h3C;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Host command codes (ASCII keys)
  localparam logic [7:0] CMD_LEFT  = 8'h41;  // 'A'
  localparam logic [7:0] CMD_RIGHT = 8'h44;  // 'D'
  localparam logic [7:0] CMD_UP    = 8'h57;  // 'W'
  localparam logic [7:0] CMD_DOWN  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_HOME  = 8'h48;  // 'H'
  localparam logic [7:0] CMD_EN    = 8'h45;  // 'E'
  localparam logic [7:0] CMD_DIS   = 8'h58;  // 'X'

  localparam int ARRAY_DIM = 8;
  localparam int WIN_DIM   = 4;
  localparam logic [ARRAY_DIM-1:0] WIN_ONES = ARRAY_DIM'((1 << WIN_DIM) - 1);

  // Frame parser state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_GET_CMD   = 2'd1;
  localparam state_t ST_GET_PHASE = 2'd2;
  localparam state_t ST_GET_EOF   = 2'd3;

  // One complete levitation setting (staged or committed)
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       en;
    logic [9:0] phase;
  } cfg_t;

  // Active 4x4 window at origin (x,y): bit 8*r+c set for r in x..x+3, c in y..y+3
  function automatic logic [63:0] win_mask_f(input logic [2:0] x, input logic [2:0] y,
                                             input logic en);
    logic [ARRAY_DIM-1:0] rows;
    logic [ARRAY_DIM-1:0] cols;
    logic [63:0]          m;
    rows = WIN_ONES << x;
    cols = WIN_ONES << y;
    m    = '0;
    for (int r = 0; r < ARRAY_DIM; r++) begin
      if (en && rows[r]) m[ARRAY_DIM*r +: ARRAY_DIM] = cols;
    end
    return m;
  endfunction

endpackage

// File: rtl/lev_win_mask.sv
// Maps a window origin and enable to the 64-bit transducer drive mask.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module lev_win_mask
  import lev_cmd_pkg::*;
(
  input  logic [2:0]  x,
  input  logic [2:0]  y,
  input  logic        en,
  output logic [63:0] mask
);

  assign mask = win_mask_f(x, y, en);

endmodule

// File: rtl/lev_cmd_ctrl.sv
// Parses FF/CMD/PHASE/3C host frames, stages settings, commits them on period_sync.
// Latency: period_sync to outputs 1 clk; a frame ending with period_sync commits that cycle.
// Backpressure: none on rx (every byte is consumed); LEV_CMD_ACK_EN adds a 1-slot ACK/NAK held while tx_busy.
module lev_cmd_ctrl
  import lev_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int INIT_X      = 3,
  parameter int INIT_Y      = 3,
  parameter int POS_MAX     = 4,
  parameter int PHASE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        period_sync,
`ifdef LEV_CMD_ACK_EN
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
`endif
  output logic [2:0]  pos_x,
  output logic [2:0]  pos_y,
  output logic [9:0]  phase_delay,
  output logic [63:0] win_mask,
  output logic        cfg_update,
  output logic        frame_busy,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int          CW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  X0       = 3'(INIT_X);
  localparam logic [2:0]  Y0       = 3'(INIT_Y);
  localparam logic [2:0]  PMAX     = 3'(POS_MAX);
  localparam cfg_t        RST_CFG  = '{x: X0, y: Y0, en: 1'b1, phase: 10'd0};
  localparam logic [63:0] RST_MASK = win_mask_f(X0, Y0, 1'b1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] gap_cnt;
  logic [7:0]    cmd_q;
  logic [7:0]    phase_q;
  cfg_t          stg;
  cfg_t          nxt_stg;
  cfg_t          commit_cfg;
  logic          pending;
  logic [63:0]   mask_nxt;
  logic          timeout;
  logic          eof_ok;
  logic          eof_bad;
  logic          commit;

  // Frame outcome and commit qualifiers; a byte arriving on the limit cycle wins over timeout
  assign timeout    = (state != ST_IDLE) && !rx_valid && (gap_cnt == TO_LAST);
  assign eof_ok     = (state == ST_GET_EOF) && rx_valid && (rx_data == EOF);
  assign eof_bad    = ((state == ST_GET_EOF) && rx_valid && (rx_data != EOF)) || timeout;
  assign commit     = period_sync && (pending || eof_ok);
  assign commit_cfg = eof_ok ? nxt_stg : stg;

  // Frame parser next state
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else if (rx_valid) begin
      case (state)
        ST_IDLE:      state_nxt = (rx_data == SOF) ? ST_GET_CMD : ST_IDLE;
        ST_GET_CMD:   state_nxt = ST_GET_PHASE;
        ST_GET_PHASE: state_nxt = ST_GET_EOF;
        default:      state_nxt = ST_IDLE;
      endcase
    end
  end

  // Staged setting the current frame would produce, relative to the staged (not committed) values
  always_comb begin
    nxt_stg       = stg;
    nxt_stg.phase = {2'b00, phase_q} << PHASE_SHIFT;
    case (cmd_q)
      CMD_LEFT:  if (stg.x != 3'd0) nxt_stg.x = stg.x - 3'd1;
      CMD_RIGHT: if (stg.x < PMAX)  nxt_stg.x = stg.x + 3'd1;
      CMD_UP:    if (stg.y < PMAX)  nxt_stg.y = stg.y + 3'd1;
      CMD_DOWN:  if (stg.y != 3'd0) nxt_stg.y = stg.y - 3'd1;
      CMD_HOME:  begin nxt_stg.x = X0; nxt_stg.y = Y0; end
      CMD_EN:    nxt_stg.en = 1'b1;
      CMD_DIS:   nxt_stg.en = 1'b0;
      default:   ;
    endcase
  end

  lev_win_mask u_win_mask (
    .x    (commit_cfg.x),
    .y    (commit_cfg.y),
    .en   (commit_cfg.en),
    .mask (mask_nxt)
  );

  // Parser state, frame payload capture and busy indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd_q      <= '0;
      phase_q    <= '0;
      frame_busy <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_busy <= (state_nxt != ST_IDLE);
      if (rx_valid && (state == ST_GET_CMD))   cmd_q   <= rx_data;
      if (rx_valid && (state == ST_GET_PHASE)) phase_q <= rx_data;
    end
  end

  // Inter-byte gap counter; held at zero while idle so a frame starts with a full budget
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    gap_cnt <= '0;
    else if (rx_valid || timeout || state == ST_IDLE) gap_cnt <= '0;
    else                                           gap_cnt <= gap_cnt + CW'(1);
  end

  // Staged settings and pending flag; the last accepted frame overwrites anything uncommitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg     <= RST_CFG;
      pending <= 1'b0;
    end else begin
      if (eof_ok) stg <= nxt_stg;
      if (commit)      pending <= 1'b0;
      else if (eof_ok) pending <= 1'b1;
    end
  end

  // Committed outputs, update strobe and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x       <= X0;
      pos_y       <= Y0;
      phase_delay <= '0;
      win_mask    <= RST_MASK;
      cfg_update  <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      cfg_update <= commit;
      frame_err  <= eof_bad;
      if (commit) begin
        pos_x       <= commit_cfg.x;
        pos_y       <= commit_cfg.y;
        phase_delay <= commit_cfg.phase;
        win_mask    <= mask_nxt;
      end
      if (eof_bad && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef LEV_CMD_ACK_EN
  logic       resp_vld;
  logic [7:0] resp_dat;

  // Single-slot response queue; a newer frame result replaces an unsent one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld <= 1'b0;
      resp_dat <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      if (eof_ok || eof_bad) begin
        resp_vld <= 1'b1;
        resp_dat <= eof_ok ? ACK : NAK;
      end else if (resp_vld && !tx_busy) begin
        tx_start <= 1'b1;
        tx_data  <= resp_dat;
        resp_vld <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lev_cmd_ctrl.sv
// Bench for lev_cmd_ctrl: directed frames from the host protocol plus randomized traffic.
// Latency: every step waits one clock edge and samples 1 time unit later.
// Backpressure: tx_busy (when present) is toggled randomly.
module tb_lev_cmd_ctrl;

  localparam int TO      = 40;
  localparam int POS_MAX = 4;
  localparam int INIT_P  = 3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        period_sync;
  logic [2:0]  pos_x;
  logic [2:0]  pos_y;
  logic [9:0]  phase_delay;
  logic [63:0] win_mask;
  logic        cfg_update;
  logic        frame_busy;
  logic        frame_err;
  logic [7:0]  err_cnt;
`ifdef LEV_CMD_ACK_EN
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
`endif

  lev_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .period_sync (period_sync),
`ifdef LEV_CMD_ACK_EN
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
`endif
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .phase_delay (phase_delay),
    .win_mask    (win_mask),
    .cfg_update  (cfg_update),
    .frame_busy  (frame_busy),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: staged (s_*) and committed (m_*) settings as plain integers
  int s_x, s_y, s_en, s_ph;
  bit s_pend;
  int m_x, m_y, m_en, m_ph;
  int m_errs;
  bit ev_acc, ev_err;
  logic [7:0] ev_cmd, ev_ph;
`ifdef LEV_CMD_ACK_EN
  bit ack_v;
  logic [7:0] ack_d, exp_txd;
  bit exp_start;
`endif

  function automatic logic [63:0] ref_mask(input int x, input int y, input int en);
    logic [63:0] m;
    m = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (en != 0 && r >= x && r <= x + 3 && c >= y && c <= y + 3) m[8*r + c] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    s_x = INIT_P; s_y = INIT_P; s_en = 1; s_ph = 0; s_pend = 0;
    m_x = INIT_P; m_y = INIT_P; m_en = 1; m_ph = 0; m_errs = 0;
    ev_acc = 0; ev_err = 0; ev_cmd = 0; ev_ph = 0;
`ifdef LEV_CMD_ACK_EN
    ack_v = 0; ack_d = 0; exp_txd = 0; exp_start = 0;
`endif
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cmd(input logic [7:0] c, input logic [7:0] ph);
    case (c)
      8'h41: s_x = (s_x > 0) ? s_x - 1 : 0;
      8'h44: s_x = (s_x < POS_MAX) ? s_x + 1 : POS_MAX;
      8'h57: s_y = (s_y < POS_MAX) ? s_y + 1 : POS_MAX;
      8'h53: s_y = (s_y > 0) ? s_y - 1 : 0;
      8'h48: begin s_x = INIT_P; s_y = INIT_P; end
      8'h45: s_en = 1;
      8'h58: s_en = 0;
      default: ;
    endcase
    s_ph = (int'(ph) * 4) % 1024;
  endtask

  // One clock step: drive inputs, advance the model by the same edge, compare every output
  task automatic tick(input bit v, input logic [7:0] d, input bit ps, input bit busy);
    bit exp_upd;
    bit exp_ferr;
    rx_valid = v; rx_data = d; period_sync = ps;
`ifdef LEV_CMD_ACK_EN
    tx_busy = ($urandom_range(0, 2) == 0);
`endif
    @(posedge clk);
    exp_upd = 0; exp_ferr = 0;
    if (ev_acc) begin apply_cmd(ev_cmd, ev_ph); s_pend = 1; end
    if (ev_err) begin exp_ferr = 1; if (m_errs < 255) m_errs++; end
    if (ps && s_pend) begin
      m_x = s_x; m_y = s_y; m_en = s_en; m_ph = s_ph; s_pend = 0; exp_upd = 1;
    end
`ifdef LEV_CMD_ACK_EN
    if (ev_acc || ev_err) begin
      ack_v = 1; ack_d = ev_acc ? 8'h06 : 8'h15; exp_start = 0;
    end else if (ack_v && !tx_busy) begin
      exp_start = 1; exp_txd = ack_d; ack_v = 0;
    end else exp_start = 0;
`endif
    ev_acc = 0; ev_err = 0;
    #1;
    rx_valid = 0; period_sync = 0;
    chk("pos_x", 64'(pos_x), 64'(m_x));
    chk("pos_y", 64'(pos_y), 64'(m_y));
    chk("phase_delay", 64'(phase_delay), 64'(m_ph));
    chk("win_mask", win_mask, ref_mask(m_x, m_y, m_en));
    chk("cfg_update", 64'(cfg_update), 64'(exp_upd));
    chk("frame_err", 64'(frame_err), 64'(exp_ferr));
    chk("err_cnt", 64'(err_cnt), 64'(m_errs));
    chk("frame_busy", 64'(frame_busy), 64'(busy));
`ifdef LEV_CMD_ACK_EN
    chk("tx_start", 64'(tx_start), 64'(exp_start));
    chk("tx_data", 64'(tx_data), 64'(exp_txd));
`endif
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] ph, input logic [7:0] eof,
                       input int gap, input bit ps_end);
    logic [7:0] b [3];
    b = '{8'hFF, c, ph};
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, b[i], 1'b0, 1'b1);
      repeat (gap) tick(1'b0, 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
    end
    if (eof == 8'h3C) begin ev_acc = 1; ev_cmd = c; ev_ph = ph; end
    else ev_err = 1;
    tick(1'b1, eof, ps_end, 1'b0);
  endtask

  task automatic abort_frame(input logic [7:0] c, input int nbytes);
    tick(1'b1, 8'hFF, 1'b0, 1'b1);
    if (nbytes > 1) tick(1'b1, c, 1'b0, 1'b1);
    if (nbytes > 2) tick(1'b1, 8'($urandom), 1'b0, 1'b1);
    repeat (TO - 1) tick(1'b0, 8'h00, ($urandom_range(0, 7) == 0), 1'b1);
    ev_err = 1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] cmds [8];
    cmds = '{8'h41, 8'h44, 8'h57, 8'h53, 8'h48, 8'h45, 8'h58, 8'h7A};
    checks = 0; errors = 0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; period_sync = 1'b0;
`ifdef LEV_CMD_ACK_EN
    tx_busy = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_mask_const", win_mask, 64'h0078787878000000);

    // 'D' with phase 0x10, then commit
    frame(8'h44, 8'h10, 8'h3C, 0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("d_pos_x_const", 64'(pos_x), 64'd4);
    chk("d_phase_const", 64'(phase_delay), 64'd64);
    chk("d_mask_const", win_mask, 64'h7878787800000000);

    // Saturation at POS_MAX, then five 'A' committed on the EOF cycle itself
    frame(8'h44, 8'h00, 8'h3C, 0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sat_hi_const", 64'(pos_x), 64'd4);
    repeat (5) frame(8'h41, 8'h00, 8'h3C, 0, 1'b1);
    chk("sat_lo_const", 64'(pos_x), 64'd0);

    // Bad EOF: error pulse, no commit
    frame(8'h57, 8'h20, 8'h00, 0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bad_eof_cnt_const", 64'(err_cnt), 64'd1);

    // Timeout after FF 53, then a normal 'S' frame
    abort_frame(8'h53, 2);
    frame(8'h53, 8'h05, 8'h3C, 0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("to_pos_y_const", 64'(pos_y), 64'd2);
    chk("to_phase_const", 64'(phase_delay), 64'd20);

    // Two 'W' frames before a single commit; back-to-back bytes with no gaps
    frame(8'h48, 8'h00, 8'h3C, 0, 1'b0);
    frame(8'h57, 8'h01, 8'h3C, 0, 1'b0);
    frame(8'h57, 8'h02, 8'h3C, 0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ww_pos_y_const", 64'(pos_y), 64'd4);
    tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Disable clears the mask, enable restores it
    frame(8'h58, 8'h00, 8'h3C, 2, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("dis_mask_const", win_mask, 64'h0);
    frame(8'h45, 8'h00, 8'h3C, 1, 1'b1);

    // Reset mid-frame discards the partial frame
    tick(1'b1, 8'hFF, 1'b0, 1'b1);
    tick(1'b1, 8'h44, 1'b0, 1'b1);
    tick(1'b1, 8'h10, 1'b0, 1'b1);
    rst_n = 1'b0;
    #20 rst_n = 1'b1;
    model_reset();
    tick(1'b1, 8'h3C, 1'b1, 1'b0);

    // Error counter saturation
    repeat (260) frame(8'h41, 8'h00, 8'h00, 0, 1'b0);
    chk("err_sat_const", 64'(err_cnt), 64'd255);
    model_reset();
    rst_n = 1'b0;
    #20 rst_n = 1'b1;
    tick(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic
    repeat (250) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 70)
        frame(cmds[$urandom_range(0, 7)], 8'($urandom),
              ($urandom_range(0, 6) == 0) ? 8'($urandom_range(0, 59)) : 8'h3C,
              $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      else if (k < 95)
        repeat ($urandom_range(1, 4))
          tick(($urandom_range(0, 1) == 1), 8'($urandom_range(0, 254)),
               ($urandom_range(0, 2) == 0), 1'b0);
      else
        abort_frame(cmds[$urandom_range(0, 7)], $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
